jump_redirect_ctrl: RTL and testbench
=====================================

// Module: jump_redirect_ctrl
// PURPOSE
//   Consumer end of the ID-stage jump signal (jmpSign). Takes the jump request plus
//   the decoded Op/Funct, computes the target and redirects the PC (J/JAL/JR).
//   Flushes the wrong-path fetch and writes the JAL link value.
//   Stalls IF/ID while a JR source register is not yet forwarded.
//   Sits between the ID decode and the PC/IF-ID pipeline registers. No delay slot.
// PARAMETERS
//   ADDR_W       32  PC/target width (bits)
//   CNT_W        16  width of the retired-jump counter
//   RS_WAIT_MAX  4   max WAIT_RS cycles before a JR timeout (>=1)
// PORTS
//   clk          in   1       clock; all state updates on posedge
//   rst          in   1       synchronous, active-high reset
//   jmpSign      in   1       jump request from ID (valid for the instr currently in ID)
//   Op           in   6       opcode of the ID instruction
//   Funct        in   6       funct of the ID instruction
//   InstrAddr    in   26      J/JAL index field
//   pc_id        in   ADDR_W  PC of the ID instruction
//   rs_data      in   ADDR_W  forwarded rs value for JR
//   rs_ready     in   1       rs_data is valid this cycle
//   stall_in     in   1       downstream pipeline stall
//   redirect     out  1       PC must load jump_target
//   jump_target  out  ADDR_W  registered redirect target, [1:0]==2'b00
//   if_id_flush  out  1       squash the IF/ID contents
//   stall_out    out  1       hold the PC and IF/ID (waiting on rs for JR)
//   link_we      out  1       one-cycle write of link_data to $31
//   link_data    out  ADDR_W  pc_id+4 of the JAL
//   jump_count   out  CNT_W   retired jumps, wraps modulo 2^CNT_W
//   err_timeout  out  1       sticky: JR exceeded RS_WAIT_MAX
//   err_align    out  1       sticky: JR rs_data[1:0] != 0
// BEHAVIOUR
//   Decode: J = Op 6'h02; JAL = Op 6'h03; JR = Op 6'h00 with Funct 6'h08.
//     jmpSign with any other Op/Funct is ignored (stays in IDLE).
//   Reset: state IDLE. All outputs 0, including jump_count and both sticky errors.
//     Reset mid-operation aborts any pending jump; no redirect and no link write are emitted.
//   Jump targets:
//     J/JAL: target = {pc_id+4 [ADDR_W-1:28], InstrAddr, 2'b00}, latched at the accepting edge.
//     JR: target = {rs_data[ADDR_W-1:2], 2'b00}. If rs_data[1:0] != 0, set err_align.
//   FSM: IDLE, WAIT_RS, REDIRECT.
//     IDLE: on jmpSign & decoded jump & !stall_in:
//       J/JAL, or JR with rs_ready: latch target (and link_data for JAL), go to REDIRECT.
//       JR with !rs_ready: clear the wait counter, go to WAIT_RS.
//       If stall_in=1, stay in IDLE (the request is re-presented).
//     WAIT_RS: stall_out=1 every cycle.
//       On rs_ready: latch the target, go to REDIRECT.
//       Otherwise, after RS_WAIT_MAX wait cycles: set err_timeout, go to IDLE, no redirect.
//     REDIRECT: redirect=1, if_id_flush=1, jump_target stable.
//       Held unchanged while stall_in=1. Exit to IDLE on the first cycle with stall_in=0.
//       jmpSign is ignored in REDIRECT (that ID instruction is wrong-path).
//   Completion (REDIRECT & !stall_in) is a single cycle:
//     jump_count += 1 (wraps).
//     link_we=1 only if the jump is JAL.
//   Latency: J/JAL accepted at edge t gives redirect high in cycle t+1.
//     JR adds one cycle per WAIT_RS cycle.
//   Outputs are registered or decoded from the state only; no combinational path from
//     jmpSign to redirect.
//   Sticky errors are cleared only by rst.
// TESTING
//   J, pc_id=0x0040_0010, InstrAddr=0x0000100 -> next cycle redirect=1, flush=1,
//     target=0x0000_0400; jump_count=1; link_we never asserts.
//   JAL, pc_id=0x1000_0000, InstrAddr=0x3FFFFFF -> target=0x1FFF_FFFC; one-cycle link_we,
//     link_data=0x1000_0004.
//   JR, rs_ready=0 for 2 cycles then 1 with rs_data=0x0000_2000 -> stall_out high 2 cycles,
//     then redirect with target 0x2000.
//   JR, rs_ready never asserted, RS_WAIT_MAX=4 -> stall_out 4 cycles; err_timeout=1;
//     redirect never asserts; IDLE.
//   JR, rs_data=0x0000_2003 -> target=0x2000, err_align=1 held after completion.
//   REDIRECT with stall_in=1 for 3 cycles, then rst in a later WAIT_RS ->
//     redirect held 3 cycles, one count/link pulse; rst clears all outputs next edge.

Source files
------------

// File: rtl/jump_redirect_ctrl.sv
// jump_redirect_ctrl
// Consumes the ID-stage jump request and steers the front end: computes the
// J/JAL/JR target, redirects the PC, squashes the wrong-path IF/ID entry,
// produces the JAL link write and stalls IF/ID while a JR source is pending.
module jump_redirect_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 16,
  parameter int RS_WAIT_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jmpSign,
  input  logic [5:0]        Op,
  input  logic [5:0]        Funct,
  input  logic [25:0]       InstrAddr,
  input  logic [ADDR_W-1:0] pc_id,
  input  logic [ADDR_W-1:0] rs_data,
  input  logic              rs_ready,
  input  logic              stall_in,
  output logic              redirect,
  output logic [ADDR_W-1:0] jump_target,
  output logic              if_id_flush,
  output logic              stall_out,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_data,
  output logic [CNT_W-1:0]  jump_count,
  output logic              err_timeout,
  output logic              err_align
);

  localparam int WAIT_W = (RS_WAIT_MAX > 1) ? $clog2(RS_WAIT_MAX) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RS_WAIT_MAX - 1);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] FN_JR      = 6'h08;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RS  = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   waitCnt_q, waitCnt_d;
  logic [ADDR_W-1:0]   target_q, target_d;
  logic [ADDR_W-1:0]   linkData_q, linkData_d;
  logic                isJal_q, isJal_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                linkWe_q, linkWe_d;
  logic                errTimeout_q, errTimeout_d;
  logic                errAlign_q, errAlign_d;
  logic                redirect_q, redirect_d;
  logic                stall_q, stall_d;

  logic                decJ, decJal, decJr;
  logic [ADDR_W-1:0]   pcPlus4;
  logic [ADDR_W-1:0]   absTarget;
  logic [ADDR_W-1:0]   regTarget;
  logic                rsMisaligned;

  // Decode the ID instruction and form both candidate targets.
  always_comb begin
    decJal       = (Op == OP_JAL);
    decJ         = (Op == OP_J);
    decJr        = (Op == OP_SPECIAL) && (Funct == FN_JR);
    pcPlus4      = pc_id + ADDR_W'(4);
    absTarget    = {pcPlus4[ADDR_W-1:28], InstrAddr, 2'b00};
    regTarget    = {rs_data[ADDR_W-1:2], 2'b00};
    rsMisaligned = (rs_data[1:0] != 2'b00);
  end

  // Next-state logic: accept a jump, wait for the JR source, then hold the redirect until the pipeline lets it through.
  always_comb begin
    state_d      = state_q;
    waitCnt_d    = waitCnt_q;
    target_d     = target_q;
    linkData_d   = linkData_q;
    isJal_d      = isJal_q;
    count_d      = count_q;
    linkWe_d     = 1'b0;
    errTimeout_d = errTimeout_q;
    errAlign_d   = errAlign_q;

    case (state_q)
      IDLE: begin
        if (jmpSign && !stall_in && (decJ || decJal || decJr)) begin
          if (decJr) begin
            isJal_d = 1'b0;
            if (rs_ready) begin
              target_d = regTarget;
              if (rsMisaligned) begin
                errAlign_d = 1'b1;
              end
              state_d = REDIRECT;
            end else begin
              waitCnt_d = '0;
              state_d   = WAIT_RS;
            end
          end else begin
            target_d = absTarget;
            isJal_d  = decJal;
            if (decJal) begin
              linkData_d = pcPlus4;
            end
            state_d = REDIRECT;
          end
        end
      end

      WAIT_RS: begin
        if (rs_ready) begin
          target_d = regTarget;
          if (rsMisaligned) begin
            errAlign_d = 1'b1;
          end
          state_d = REDIRECT;
        end else if (waitCnt_q == WAIT_LAST) begin
          errTimeout_d = 1'b1;
          state_d      = IDLE;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end

      REDIRECT: begin
        if (!stall_in) begin
          count_d  = count_q + 1'b1;
          linkWe_d = isJal_q;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    redirect_d = (state_d == REDIRECT);
    stall_d    = (state_d == WAIT_RS);
  end

  // State and registered outputs; reset abandons any jump in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      waitCnt_q    <= '0;
      target_q     <= '0;
      linkData_q   <= '0;
      isJal_q      <= 1'b0;
      count_q      <= '0;
      linkWe_q     <= 1'b0;
      errTimeout_q <= 1'b0;
      errAlign_q   <= 1'b0;
      redirect_q   <= 1'b0;
      stall_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      waitCnt_q    <= waitCnt_d;
      target_q     <= target_d;
      linkData_q   <= linkData_d;
      isJal_q      <= isJal_d;
      count_q      <= count_d;
      linkWe_q     <= linkWe_d;
      errTimeout_q <= errTimeout_d;
      errAlign_q   <= errAlign_d;
      redirect_q   <= redirect_d;
      stall_q      <= stall_d;
    end
  end

  assign redirect    = redirect_q;
  assign if_id_flush = redirect_q;
  assign stall_out   = stall_q;
  assign jump_target = target_q;
  assign link_we     = linkWe_q;
  assign link_data   = linkData_q;
  assign jump_count  = count_q;
  assign err_timeout = errTimeout_q;
  assign err_align   = errAlign_q;

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// tb_jump_redirect_ctrl
// Directed scenarios followed by a randomized run, all compared cycle by cycle
// against a behavioural model of the jump controller.
module tb_jump_redirect_ctrl;

  localparam int ADDR_W      = 32;
  localparam int CNT_W       = 4;
  localparam int RS_WAIT_MAX = 4;

  logic              clk;
  logic              rst;
  logic              jmpSign;
  logic [5:0]        Op;
  logic [5:0]        Funct;
  logic [25:0]       InstrAddr;
  logic [ADDR_W-1:0] pc_id;
  logic [ADDR_W-1:0] rs_data;
  logic              rs_ready;
  logic              stall_in;
  logic              redirect;
  logic [ADDR_W-1:0] jump_target;
  logic              if_id_flush;
  logic              stall_out;
  logic              link_we;
  logic [ADDR_W-1:0] link_data;
  logic [CNT_W-1:0]  jump_count;
  logic              err_timeout;
  logic              err_align;

  int checks;
  int errors;

  // Behavioural model of the controller's visible state
  bit          mRedir;
  bit          mWaiting;
  int          mWaitUsed;
  bit [31:0]   mTarget;
  bit [31:0]   mLinkData;
  bit          mIsJal;
  int          mCount;
  bit          mLinkPulse;
  bit          mErrT;
  bit          mErrA;

  jump_redirect_ctrl #(
    .ADDR_W      (ADDR_W),
    .CNT_W       (CNT_W),
    .RS_WAIT_MAX (RS_WAIT_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .jmpSign     (jmpSign),
    .Op          (Op),
    .Funct       (Funct),
    .InstrAddr   (InstrAddr),
    .pc_id       (pc_id),
    .rs_data     (rs_data),
    .rs_ready    (rs_ready),
    .stall_in    (stall_in),
    .redirect    (redirect),
    .jump_target (jump_target),
    .if_id_flush (if_id_flush),
    .stall_out   (stall_out),
    .link_we     (link_we),
    .link_data   (link_data),
    .jump_count  (jump_count),
    .err_timeout (err_timeout),
    .err_align   (err_align)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%08h expected=%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("redirect",    {31'd0, redirect},    {31'd0, mRedir});
    checkOutput("if_id_flush", {31'd0, if_id_flush}, {31'd0, mRedir});
    checkOutput("stall_out",   {31'd0, stall_out},   {31'd0, mWaiting});
    checkOutput("jump_target", jump_target,          mTarget);
    checkOutput("link_we",     {31'd0, link_we},     {31'd0, mLinkPulse});
    checkOutput("link_data",   link_data,            mLinkData);
    checkOutput("jump_count",  {28'd0, jump_count},  mCount);
    checkOutput("err_timeout", {31'd0, err_timeout}, {31'd0, mErrT});
    checkOutput("err_align",   {31'd0, err_align},   {31'd0, mErrA});
  endtask

  function automatic void takeJr(input bit [31:0] rs);
    mTarget = rs & 32'hFFFF_FFFC;
    if ((rs & 32'h3) != 0) mErrA = 1'b1;
    mRedir = 1'b1;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs
  task automatic modelStep();
    bit pulse;
    bit [31:0] pc4;
    pulse = 1'b0;
    if (rst) begin
      mRedir = 0; mWaiting = 0; mWaitUsed = 0; mTarget = 0; mLinkData = 0;
      mIsJal = 0; mCount = 0; mLinkPulse = 0; mErrT = 0; mErrA = 0;
      return;
    end
    if (mRedir) begin
      if (!stall_in) begin
        mRedir = 1'b0;
        mCount = (mCount + 1) % (1 << CNT_W);
        pulse  = mIsJal;
      end
    end else if (mWaiting) begin
      if (rs_ready) begin
        mWaiting = 1'b0;
        takeJr(rs_data);
      end else begin
        mWaitUsed++;
        if (mWaitUsed == RS_WAIT_MAX) begin
          mWaiting = 1'b0;
          mErrT    = 1'b1;
        end
      end
    end else if (jmpSign && !stall_in) begin
      pc4 = pc_id + 32'd4;
      if (Op == 6'h02 || Op == 6'h03) begin
        mTarget = (pc4 & 32'hF000_0000) | ({6'd0, InstrAddr} << 2);
        mIsJal  = (Op == 6'h03);
        if (mIsJal) mLinkData = pc4;
        mRedir = 1'b1;
      end else if (Op == 6'h00 && Funct == 6'h08) begin
        mIsJal = 1'b0;
        if (rs_ready) takeJr(rs_data);
        else begin
          mWaiting  = 1'b1;
          mWaitUsed = 0;
        end
      end
    end
    mLinkPulse = pulse;
  endtask

  // Drive one cycle of inputs, let the DUT take the edge, then compare everything
  task automatic applyStimulus(input bit r, input bit js, input bit [5:0] op, input bit [5:0] fn,
                               input bit [25:0] ia, input bit [31:0] pc, input bit [31:0] rs,
                               input bit rdy, input bit st);
    @(negedge clk);
    rst = r; jmpSign = js; Op = op; Funct = fn; InstrAddr = ia;
    pc_id = pc; rs_data = rs; rs_ready = rdy; stall_in = st;
    modelStep();
    @(posedge clk);
    #1;
    compareAll();
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 6'h00, 6'h00, 26'd0, 32'd0, 32'd0, 0, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; jmpSign = 0; Op = 0; Funct = 0; InstrAddr = 0;
    pc_id = 0; rs_data = 0; rs_ready = 0; stall_in = 0;

    // Reset state
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 6'h02, 0, 26'h1, 32'h100, 0, 0, 0);
    checkOutput("reset_count", {28'd0, jump_count}, 32'd0);

    // J: redirect the cycle after acceptance, no link write
    applyStimulus(0, 1, 6'h02, 6'h00, 26'h0000100, 32'h0040_0010, 0, 0, 0);
    checkOutput("j_redirect", {31'd0, redirect}, 32'd1);
    checkOutput("j_target", jump_target, 32'h0000_0400);
    idleCycle();
    checkOutput("j_count", {28'd0, jump_count}, 32'd1);
    checkOutput("j_no_link", {31'd0, link_we}, 32'd0);

    // JAL: target keeps pc+4 upper bits, one-cycle link write
    applyStimulus(0, 1, 6'h03, 6'h00, 26'h3FF_FFFF, 32'h1000_0000, 0, 0, 0);
    checkOutput("jal_target", jump_target, 32'h1FFF_FFFC);
    idleCycle();
    checkOutput("jal_link_we", {31'd0, link_we}, 32'd1);
    checkOutput("jal_link_data", link_data, 32'h1000_0004);
    idleCycle();
    checkOutput("jal_link_pulse_end", {31'd0, link_we}, 32'd0);

    // JR waiting two cycles for rs
    applyStimulus(0, 1, 6'h00, 6'h08, 0, 32'h40, 32'h0, 0, 0);
    checkOutput("jr_stall1", {31'd0, stall_out}, 32'd1);
    applyStimulus(0, 0, 6'h00, 6'h00, 0, 0, 32'h0, 0, 0);
    checkOutput("jr_stall2", {31'd0, stall_out}, 32'd1);
    applyStimulus(0, 0, 6'h00, 6'h00, 0, 0, 32'h0000_2000, 1, 0);
    checkOutput("jr_target", jump_target, 32'h0000_2000);
    idleCycle();

    // JR timeout: rs never arrives
    applyStimulus(0, 1, 6'h00, 6'h08, 0, 32'h80, 0, 0, 0);
    repeat (RS_WAIT_MAX) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("jr_timeout_err", {31'd0, err_timeout}, 32'd1);
    checkOutput("jr_timeout_idle", {31'd0, stall_out | redirect}, 32'd0);

    // JR misaligned source
    applyStimulus(0, 1, 6'h00, 6'h08, 0, 32'h90, 32'h0000_2003, 1, 0);
    checkOutput("jr_align_target", jump_target, 32'h0000_2000);
    idleCycle();
    idleCycle();
    checkOutput("jr_align_sticky", {31'd0, err_align}, 32'd1);

    // Stall held redirect, then reset during a later WAIT_RS
    applyStimulus(0, 1, 6'h03, 0, 26'h55, 32'h2000_0000, 0, 0, 0);
    repeat (3) applyStimulus(0, 1, 6'h02, 0, 26'h77, 0, 0, 0, 1);
    checkOutput("stall_redirect_held", {31'd0, redirect}, 32'd1);
    idleCycle();
    idleCycle();
    applyStimulus(0, 1, 6'h00, 6'h08, 0, 32'h10, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_clears_stall", {31'd0, stall_out}, 32'd0);
    checkOutput("rst_clears_err", {30'd0, err_timeout, err_align}, 32'd0);

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      bit [5:0] op, fn;
      bit [31:0] rs;
      int sel;
      sel = $urandom_range(0, 7);
      fn  = 6'($urandom);
      case (sel)
        0, 1:    op = 6'h02;
        2, 3:    op = 6'h03;
        4, 5: begin op = 6'h00; fn = 6'h08; end
        6:       op = 6'h00;
        default: op = 6'($urandom);
      endcase
      rs = $urandom;
      if ($urandom_range(0, 3) != 0) rs[1:0] = 2'b00;
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, op, fn,
                    26'($urandom), $urandom, rs, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
